// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: IF stage of the 5-stage pipeline.
// Owns the fetch PC, handshakes with a variable-latency instruction memory
// (imemReq/imemReady), presents one instruction+PC per accepted fetch to
// IF/ID, holds it across downstream stalls and discards wrong-path fetches.
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   stall                   IF/ID cannot accept this cycle
//   redirect/redirectTarget flush and refetch from the target
//   halt                    stop fetching until reset
//   imemReq/imemAddr        memory request valid / word-aligned address
//   imemReady/imemData      memory completion / instruction
//   instructionOut/pcOut    instruction and its PC towards IF/ID
//   validOut                outputs meaningful (0 = bubble, outputs 0)
//   halted                  unit sits in HALTED
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectTarget,
  input  logic        halt,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] instructionOut,
  output logic [31:0] pcOut,
  output logic        validOut,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_HOLD   = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] drain_pc_q, drain_pc_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  // Set when a halt arrives while a request is still in flight; the
  // drain then ends in HALTED instead of FETCH.
  logic        halt_pend_q, halt_pend_d;

  logic [31:0] redirect_pc;
  assign redirect_pc = {redirectTarget[31:2], 2'b00};

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      fetch_pc_q  <= RESET_PC;
      drain_pc_q  <= 32'h0;
      buf_pc_q    <= 32'h0;
      buf_instr_q <= 32'h0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drain_pc_q  <= drain_pc_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  // Next-state logic; priority is halt > redirect > stall.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drain_pc_d  = drain_pc_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    halt_pend_d = halt_pend_q;
    case (state_q)
      S_FETCH: begin
        if (halt) begin
          if (imemReady) begin
            state_d = S_HALTED;
          end else begin
            drain_pc_d  = fetch_pc_q;
            halt_pend_d = 1'b1;
            state_d     = S_DRAIN;
          end
        end else if (redirect) begin
          fetch_pc_d = redirect_pc;
          // Request still in flight: keep its address on the bus until
          // the memory completes it, then drop the data.
          if (!imemReady) begin
            drain_pc_d = fetch_pc_q;
            state_d    = S_DRAIN;
          end
        end else if (imemReady) begin
          if (stall) begin
            buf_pc_d    = fetch_pc_q;
            buf_instr_d = imemData;
            state_d     = S_HOLD;
          end else begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
          end
        end
      end
      S_HOLD: begin
        if (halt) begin
          state_d = S_HALTED;
        end else if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = S_FETCH;
        end else if (!stall) begin
          fetch_pc_d = buf_pc_q + PC_STEP;
          state_d    = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (redirect) fetch_pc_d = redirect_pc;
        if (halt) halt_pend_d = 1'b1;
        if (imemReady) begin
          state_d     = (halt || halt_pend_q) ? S_HALTED : S_FETCH;
          halt_pend_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output logic; everything is forced quiet while reset is high.
  always_comb begin
    imemReq        = 1'b0;
    imemAddr       = 32'h0;
    instructionOut = 32'h0;
    pcOut          = 32'h0;
    validOut       = 1'b0;
    halted         = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          imemReq  = 1'b1;
          imemAddr = {fetch_pc_q[31:2], 2'b00};
          if (imemReady && !halt && !redirect) begin
            validOut       = 1'b1;
            instructionOut = imemData;
            pcOut          = fetch_pc_q;
          end
        end
        S_HOLD: begin
          if (!halt && !redirect) begin
            validOut       = 1'b1;
            instructionOut = buf_instr_q;
            pcOut          = buf_pc_q;
          end
        end
        S_DRAIN: begin
          imemReq  = 1'b1;
          imemAddr = {drain_pc_q[31:2], 2'b00};
        end
        S_HALTED: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
